// File: rtl/condlogic_if.sv
// Decoder-to-condlogic bundle: write requests in, gated enables and flag state out.
interface condlogic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondExD;
  logic       Undef;

  modport master (
    output Cond, ALUFlags, FlagW,
    output PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite,
    input  Flags, CondExD, Undef
  );

  modport slave (
    input  Cond, ALUFlags, FlagW,
    input  PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite,
    output Flags, CondExD, Undef
  );
endinterface

// File: rtl/condlogic.sv
// Conditional-execution unit: NZCV register, condition check, write gating.
// CONDLOGIC_NV_TRAP_EN: Cond=1111 never executes and sets a sticky Undef.
module condlogic (
  input logic        clk,
  input logic        reset,
  condlogic_if.slave bus
);
  logic [3:0] flags;
  logic       n, z, c, v;
  logic       cond_ex;
  logic       cond_ex_d;
  logic [1:0] flag_write;
  logic       undef;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    unique case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      4'b1111: begin
`ifdef CONDLOGIC_NV_TRAP_EN
        cond_ex = 1'b0;
`else
        cond_ex = 1'b1;
`endif
      end
    endcase
  end

  // Gating uses pre-update flags; new flags are seen next cycle.
  assign flag_write = bus.FlagW & {2{cond_ex}};

  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= 4'b0000;
      cond_ex_d <= 1'b0;
    end else begin
      if (flag_write[1])
        flags[3:2] <= bus.ALUFlags[3:2];
      if (flag_write[0])
        flags[1:0] <= bus.ALUFlags[1:0];
      cond_ex_d <= cond_ex;
    end
  end

`ifdef CONDLOGIC_NV_TRAP_EN
  logic nv_req;

  assign nv_req = (bus.Cond == 4'b1111) &
                  (bus.RegW | bus.MemW |
                   bus.PCS | (|bus.FlagW));

  always_ff @(posedge clk) begin
    if (reset)
      undef <= 1'b0;
    else if (nv_req)
      undef <= 1'b1;
  end
`else
  assign undef = 1'b0;
`endif

  // Fetch increment bypasses the condition check.
  assign bus.PCWrite  = (bus.PCS & cond_ex_d) | bus.NextPC;
  assign bus.RegWrite = bus.RegW & cond_ex_d;
  assign bus.MemWrite = bus.MemW & cond_ex_d;
  assign bus.Flags    = flags;
  assign bus.CondExD  = cond_ex_d;
  assign bus.Undef    = undef;
endmodule

// File: tb/tb_condlogic.sv
// Directed vector bench for condlogic.
// Honours CONDLOGIC_NV_TRAP_EN for the Cond=1111 expectations.
module tb_condlogic;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  condlogic_if bus ();

  condlogic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pcs;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic [3:0] e_flags;
    logic       e_cex;
    logic       e_regwr;
    logic       e_memwr;
    logic       e_pcwr;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic [3:0] cnd,
    input logic [3:0] alu, input logic [1:0] fw,
    input logic pcs, input logic np,
    input logic rw, input logic mw,
    input logic [3:0] ef, input logic ec,
    input logic er, input logic em, input logic ep
  );
    vec_t t;
    t.rst = r; t.cond = cnd; t.alu = alu;
    t.flagw = fw; t.pcs = pcs; t.nextpc = np;
    t.regw = rw; t.memw = mw;
    t.e_flags = ef; t.e_cex = ec;
    t.e_regwr = er; t.e_memwr = em; t.e_pcwr = ep;
    return t;
  endfunction

  task automatic chk(
    input string name, input int idx,
    input logic [3:0] act, input logic [3:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%b want=%b",
               name, idx, act, exp);
    end
  endtask

  task automatic apply(
    input logic r, input logic [3:0] cnd,
    input logic [3:0] alu, input logic [1:0] fw,
    input logic pcs, input logic np,
    input logic rw, input logic mw
  );
    @(negedge clk);
    reset        = r;
    bus.Cond     = cnd;
    bus.ALUFlags = alu;
    bus.FlagW    = fw;
    bus.PCS      = pcs;
    bus.NextPC   = np;
    bus.RegW     = rw;
    bus.MemW     = mw;
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[16];
  logic [3:0] fset[6];
  logic [14:0] masks[6];
  logic        nv_cex;
  logic [3:0]  nv_flags;
  logic        nv_undef;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.Cond = 4'b0; bus.ALUFlags = 4'b0;
    bus.FlagW = 2'b0; bus.PCS = 1'b0;
    bus.NextPC = 1'b0; bus.RegW = 1'b0;
    bus.MemW = 1'b0;

    //           r  cond     alu      fw     pcs np rw mw  flags   cx rw mw pc
    vecs[0]  = mk(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 1);
    vecs[1]  = mk(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 1);
    vecs[2]  = mk(0, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 4'b1100, 1, 0, 0, 0);
    vecs[3]  = mk(0, 4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0, 4'b1111, 1, 0, 0, 0);
    vecs[4]  = mk(0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0);
    vecs[5]  = mk(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 1, 1, 4'b0000, 0, 0, 0, 0);
    vecs[6]  = mk(0, 4'b0001, 4'b0000, 2'b00, 1, 0, 1, 1, 4'b0000, 1, 1, 1, 1);
    vecs[7]  = mk(0, 4'b0000, 4'b0000, 2'b00, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 1);
    vecs[8]  = mk(0, 4'b0000, 4'b0100, 2'b11, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    vecs[9]  = mk(0, 4'b0000, 4'b0100, 2'b11, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    vecs[10] = mk(0, 4'b1110, 4'b0100, 2'b10, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0);
    vecs[11] = mk(0, 4'b0000, 4'b0000, 2'b11, 0, 0, 1, 0, 4'b0000, 1, 1, 0, 0);
    vecs[12] = mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
    vecs[13] = mk(0, 4'b1110, 4'b1010, 2'b11, 0, 0, 1, 0, 4'b1010, 1, 1, 0, 0);
    vecs[14] = mk(1, 4'b1110, 4'b1111, 2'b11, 1, 0, 1, 1, 4'b0000, 0, 0, 0, 0);
    vecs[15] = mk(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 1);

    // Bit k is the expected CondEx for Cond=k under that flag value.
    fset[0] = 4'b0000; masks[0] = 15'b101011010101010;
    fset[1] = 4'b0100; masks[1] = 15'b110011010101001;
    fset[2] = 4'b1000; masks[2] = 15'b110101010011010;
    fset[3] = 4'b0010; masks[3] = 15'b101010110100110;
    fset[4] = 4'b0001; masks[4] = 15'b110101001101010;
    fset[5] = 4'b1001; masks[5] = 15'b101011001011010;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].rst, vecs[i].cond, vecs[i].alu,
            vecs[i].flagw, vecs[i].pcs, vecs[i].nextpc,
            vecs[i].regw, vecs[i].memw);
      chk("flags",    i, bus.Flags,    vecs[i].e_flags);
      chk("condexd",  i, {3'b0, bus.CondExD},  {3'b0, vecs[i].e_cex});
      chk("regwrite", i, {3'b0, bus.RegWrite}, {3'b0, vecs[i].e_regwr});
      chk("memwrite", i, {3'b0, bus.MemWrite}, {3'b0, vecs[i].e_memwr});
      chk("pcwrite",  i, {3'b0, bus.PCWrite},  {3'b0, vecs[i].e_pcwr});
      chk("undef",    i, {3'b0, bus.Undef},    4'b0000);
    end

    for (int fi = 0; fi < 6; fi++) begin
      apply(0, 4'b1110, fset[fi], 2'b11, 0, 0, 0, 0);
      chk("sweep_load", fi, bus.Flags, fset[fi]);
      for (int ci = 0; ci < 15; ci++) begin
        apply(0, 4'(ci), 4'b0000, 2'b00, 0, 0, 1, 0);
        chk("sweep_cex", fi * 16 + ci,
            {3'b0, bus.CondExD}, {3'b0, masks[fi][ci]});
        chk("sweep_regw", fi * 16 + ci,
            {3'b0, bus.RegWrite}, {3'b0, masks[fi][ci]});
      end
    end

`ifdef CONDLOGIC_NV_TRAP_EN
    nv_cex = 1'b0; nv_flags = 4'b1001; nv_undef = 1'b1;
`else
    nv_cex = 1'b1; nv_flags = 4'b0110; nv_undef = 1'b0;
`endif
    // Flags hold 1001 from the sweep; Cond=1111 requests writes.
    apply(0, 4'b1111, 4'b0110, 2'b11, 0, 0, 1, 0);
    chk("nv_flags", 0, bus.Flags, nv_flags);
    chk("nv_cex",   0, {3'b0, bus.CondExD},  {3'b0, nv_cex});
    chk("nv_regw",  0, {3'b0, bus.RegWrite}, {3'b0, nv_cex});
    chk("nv_undef", 0, {3'b0, bus.Undef},    {3'b0, nv_undef});
    apply(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
    chk("nv_cex",   1, {3'b0, bus.CondExD},  4'b0001);
    chk("nv_regw",  1, {3'b0, bus.RegWrite}, 4'b0001);
    chk("nv_undef", 1, {3'b0, bus.Undef},    {3'b0, nv_undef});
    apply(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    chk("nv_undef", 2, {3'b0, bus.Undef},    {3'b0, nv_undef});
    apply(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    chk("nv_undef", 3, {3'b0, bus.Undef},    4'b0000);
    chk("nv_flags", 3, bus.Flags, 4'b0000);
    apply(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    chk("nv_undef", 4, {3'b0, bus.Undef},    4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
